input_conditioner: RTL and testbench

//   Front end for the stopwatch top level. Takes the raw board buttons (RESET, PAUSE) and switches (SEL, ADJ),

---
 rtl/input_conditioner.sv | 105 ++++++++++
 tb/tb_input_conditioner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Synchronises and debounces the stopwatch buttons and switches. Produces clean levels,
// one-cycle press pulses and the run/pause toggle state.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic btn_reset,
  input  logic btn_pause,
  input  logic sw_sel,
  input  logic sw_adj,
  output logic reset_lvl,
  output logic reset_pulse,
  output logic pause_pulse,
  output logic paused,
  output logic sel,
  output logic adj
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam int CH_RESET = 0;
  localparam int CH_PAUSE = 1;
  localparam int CH_SEL   = 2;
  localparam int CH_ADJ   = 3;
  localparam int NUM_CH   = 4;

  typedef enum logic {
    RUN    = 1'b0,
    PAUSED = 1'b1
  } state_t;

  logic [NUM_CH-1:0] raw;
  logic [NUM_CH-1:0] s0;
  logic [NUM_CH-1:0] s1;
  logic [NUM_CH-1:0] db;
  logic [NUM_CH-1:0] db_q;
  logic [NUM_CH-1:0] rise;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  state_t state_q;
  state_t state_d;

  assign raw = {sw_adj, sw_sel, btn_pause, btn_reset};

  // Any return of s1 to the debounced level restarts the window, so a glitch
  // shorter than the window never reaches db.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      s0   <= '0;
      s1   <= '0;
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s0   <= raw;
      s1   <= s0;
      db_q <= db;
      for (int i = 0; i < NUM_CH; i++) begin
        if (s1[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          db[i]  <= s1[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign rise = db & ~db_q;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      reset_pulse <= 1'b0;
      pause_pulse <= 1'b0;
      state_q     <= RUN;
    end else begin
      reset_pulse <= rise[CH_RESET];
      pause_pulse <= rise[CH_PAUSE];
      state_q     <= state_d;
    end
  end

  // A held reset button (which includes its own rising cycle) pins the state to RUN.
  always_comb begin
    state_d = state_q;
    if (db[CH_RESET]) begin
      state_d = RUN;
    end else if (rise[CH_PAUSE]) begin
      state_d = (state_q == RUN) ? PAUSED : RUN;
    end
  end

  assign paused    = (state_q == PAUSED);
  assign reset_lvl = db[CH_RESET];
  assign sel       = db[CH_SEL];
  assign adj       = db[CH_ADJ];

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-cycle debounce window.
module tb_input_conditioner;

  localparam int DB = 4;

  logic clk;
  logic RESET_N;
  logic btn_reset;
  logic btn_pause;
  logic sw_sel;
  logic sw_adj;
  logic reset_lvl;
  logic reset_pulse;
  logic pause_pulse;
  logic paused;
  logic sel;
  logic adj;

  int vector_count = 0;
  int miss_count   = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .RESET_N     (RESET_N),
    .btn_reset   (btn_reset),
    .btn_pause   (btn_pause),
    .sw_sel      (sw_sel),
    .sw_adj      (sw_adj),
    .reset_lvl   (reset_lvl),
    .reset_pulse (reset_pulse),
    .pause_pulse (pause_pulse),
    .paused      (paused),
    .sel         (sel),
    .adj         (adj)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic p, input logic s, input logic a);
    btn_reset = r;
    btn_pause = p;
    sw_sel    = s;
    sw_adj    = a;
  endtask

  // Advance one clock and land 1 time unit past the edge, away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {reset_lvl, reset_pulse, pause_pulse, paused, sel, adj};
  endfunction

  int pattern [9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    RESET_N = 1'b0;
    applyStimulus(0, 0, 0, 0);
    repeat (3) step();
    checkOutput("reset_hold", 32'(outs()), 32'd0);
    RESET_N = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 1; i <= 20; i++) begin
      step();
      checkOutput("idle_outs", 32'(outs()), 32'd0);
    end

    $display("[TB] clean pause presses");
    applyStimulus(0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("press1_pulse", 32'(pause_pulse), 32'(i == 7));
      checkOutput("press1_paused", 32'(paused), 32'(i >= 7));
    end
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("release1_pulse", 32'(pause_pulse), 32'd0);
      checkOutput("release1_paused", 32'(paused), 32'd1);
    end
    applyStimulus(0, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("press2_pulse", 32'(pause_pulse), 32'(i == 7));
      checkOutput("press2_paused", 32'(paused), 32'(i < 7));
    end
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("release2_pulse", 32'(pause_pulse), 32'd0);
    end

    $display("[TB] bouncy pause press");
    for (int i = 0; i < 16; i++) begin
      btn_pause = (i < 9) ? pattern[i][0] : 1'b1;
      step();
      checkOutput("bounce_pulse", 32'(pause_pulse), 32'(i == 11));
      checkOutput("bounce_paused", 32'(paused), 32'(i >= 11));
    end
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("bounce_rel_paused", 32'(paused), 32'd1);
    end

    $display("[TB] simultaneous reset and pause");
    applyStimulus(1, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("both_reset_pulse", 32'(reset_pulse), 32'(i == 7));
      checkOutput("both_pause_pulse", 32'(pause_pulse), 32'(i == 7));
      checkOutput("both_paused", 32'(paused), 32'(i < 7));
      checkOutput("both_reset_lvl", 32'(reset_lvl), 32'(i >= 6));
    end
    applyStimulus(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("held_rel_paused", 32'(paused), 32'd0);
    end
    applyStimulus(1, 1, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("held_press_paused", 32'(paused), 32'd0);
      checkOutput("held_press_pulse", 32'(pause_pulse), 32'(i == 7));
    end
    applyStimulus(0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      step();
      checkOutput("reset_rel_pulse", 32'(reset_pulse), 32'd0);
      checkOutput("reset_rel_lvl", 32'(reset_lvl), 32'(i < 6));
      checkOutput("reset_rel_paused", 32'(paused), 32'd0);
    end

    $display("[TB] switches");
    applyStimulus(0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput("sel_rise", 32'(sel), 32'(i >= 6));
    end
    for (int i = 0; i < 40; i++) begin
      sw_adj = 1'(i >> 1);
      step();
      checkOutput("adj_toggle", 32'(adj), 32'd0);
    end
    sw_adj = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput("adj_settle", 32'(adj), 32'd0);
    end

    $display("[TB] reset mid-count");
    sw_adj = 1'b1;
    repeat (4) step();
    checkOutput("adj_midcount", 32'(adj), 32'd0);
    RESET_N = 1'b0;
    #1;
    checkOutput("async_clear_adj", 32'(adj), 32'd0);
    checkOutput("async_clear_sel", 32'(sel), 32'd0);
    for (int i = 1; i <= 2; i++) begin
      step();
      checkOutput("reset_low_outs", 32'(outs()), 32'd0);
    end
    RESET_N = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checkOutput("post_reset_adj", 32'(adj), 32'(i >= 6));
      checkOutput("post_reset_sel", 32'(sel), 32'(i >= 6));
      checkOutput("post_reset_paused", 32'(paused), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
